// File: rtl/br_dispatch_queue.sv
// Branch dispatch queue: circular buffer between rename and the branch issue queue.
// Optional same-cycle bypass into an empty queue under `BR_DISPATCH_BYPASS_EN.
module br_dispatch_queue #(
   parameter int LANES   = 2,
   parameter int DEPTH   = 8,
   parameter int ENTRY_W = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*ENTRY_W-1:0]   in_entry,
   output logic                       in_ready,
   input  logic                       iq_full,
   output logic                       out_wen,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*ENTRY_W-1:0]   out_entry,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]            head_q, head_d;
   logic [PW-1:0]            tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;
   logic [ENTRY_W-1:0]       slot_mem [DEPTH];

   logic [LANES*ENTRY_W-1:0] comp_entry;
   logic [LANES-1:0]         comp_valid;
   logic [CW-1:0]            n_in;
   logic [CW-1:0]            n_enq;
   logic [CW-1:0]            n_deq;
   logic [CW-1:0]            deq_max;
   logic                     any_in;
   logic                     accept;

   // Pack valid lanes toward lane 0, keeping ascending lane order.
   always_comb begin
      comp_entry = '0;
      comp_valid = '0;
      n_in       = '0;
      for (int k = 0; k < LANES; k++) begin
         if (in_valid[k]) begin
            for (int j = 0; j < LANES; j++) begin
               if (CW'(j) == n_in) begin
                  comp_entry[j*ENTRY_W +: ENTRY_W] =
                     in_entry[k*ENTRY_W +: ENTRY_W];
               end
            end
            n_in = n_in + CW'(1);
         end
      end
      for (int j = 0; j < LANES; j++) begin
         comp_valid[j] = CW'(j) < n_in;
      end
   end

   assign in_ready = (CW'(DEPTH) - count_q) >= CW'(LANES);
   assign any_in   = |in_valid;
   assign accept   = in_ready && any_in && !flush;
   assign deq_max  = (count_q < CW'(LANES)) ? count_q : CW'(LANES);
   assign count    = count_q;

   always_comb begin
      out_wen   = (count_q != '0) && !iq_full && !flush;
      out_valid = '0;
      out_entry = '0;
      for (int k = 0; k < LANES; k++) begin
         out_valid[k] = CW'(k) < count_q;
         out_entry[k*ENTRY_W +: ENTRY_W] = slot_mem[head_q + PW'(k)];
      end
      n_enq = accept ? n_in : '0;
      n_deq = out_wen ? deq_max : '0;
`ifdef BR_DISPATCH_BYPASS_EN
      // Empty queue with a free issue queue: forward without storing.
      if ((count_q == '0) && !iq_full && !flush) begin
         out_wen   = any_in;
         out_valid = comp_valid;
         out_entry = comp_entry;
         n_enq     = '0;
      end
`endif
      head_d  = head_q + n_deq[PW-1:0];
      tail_d  = tail_q + n_enq[PW-1:0];
      count_d = count_q + n_enq - n_deq;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (CW'(k) < n_enq) begin
            slot_mem[tail_q + PW'(k)] <= comp_entry[k*ENTRY_W +: ENTRY_W];
         end
      end
   end

endmodule

// File: tb/tb_br_dispatch_queue.sv
// Bench for br_dispatch_queue: queue-based reference model plus directed scenarios.
module tb_br_dispatch_queue;

   localparam int LANES   = 2;
   localparam int DEPTH   = 8;
   localparam int ENTRY_W = 64;
   localparam int OW      = LANES * ENTRY_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              flush = 1'b0;
   logic [LANES-1:0]  in_valid = '0;
   logic [OW-1:0]     in_entry = '0;
   logic              in_ready;
   logic              iq_full = 1'b0;
   logic              out_wen;
   logic [LANES-1:0]  out_valid;
   logic [OW-1:0]     out_entry;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;
   logic [ENTRY_W-1:0] mq[$];

   always #5 clk = ~clk;

   br_dispatch_queue #(
      .LANES(LANES), .DEPTH(DEPTH), .ENTRY_W(ENTRY_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_entry(in_entry), .in_ready(in_ready),
      .iq_full(iq_full), .out_wen(out_wen), .out_valid(out_valid),
      .out_entry(out_entry), .count(count)
   );

   task automatic chk(input string name, input logic [OW-1:0] act,
                      input logic [OW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare DUT against the queue model for this cycle, then advance the model.
   task automatic model_cycle();
      int sz;
      bit exp_ready, exp_wen, byp;
      logic [LANES-1:0] exp_valid;
      logic [OW-1:0] exp_e, act_e;
      logic [ENTRY_W-1:0] lst[$];
      int ndeq;
      sz = mq.size();
      if (reset) begin
         mq.delete();
         return;
      end
      lst.delete();
      for (int k = 0; k < LANES; k++)
         if (in_valid[k]) lst.push_back(in_entry[k*ENTRY_W +: ENTRY_W]);
      exp_ready = (DEPTH - sz) >= LANES;
      byp = 1'b0;
`ifdef BR_DISPATCH_BYPASS_EN
      byp = (sz == 0) && !iq_full && !flush;
`endif
      exp_valid = '0;
      exp_e = '0;
      if (byp) begin
         exp_wen = lst.size() != 0;
         for (int k = 0; k < lst.size(); k++) begin
            exp_valid[k] = 1'b1;
            exp_e[k*ENTRY_W +: ENTRY_W] = lst[k];
         end
      end else begin
         exp_wen = (sz != 0) && !iq_full && !flush;
         for (int k = 0; k < LANES; k++) begin
            if (k < sz) begin
               exp_valid[k] = 1'b1;
               exp_e[k*ENTRY_W +: ENTRY_W] = mq[k];
            end
         end
      end
      act_e = '0;
      for (int k = 0; k < LANES; k++)
         if (exp_valid[k])
            act_e[k*ENTRY_W +: ENTRY_W] = out_entry[k*ENTRY_W +: ENTRY_W];
      chk("m_count", OW'(count), OW'(sz));
      chk("m_in_ready", OW'(in_ready), OW'(exp_ready));
      chk("m_out_wen", OW'(out_wen), OW'(exp_wen));
      chk("m_out_valid", OW'(out_valid), OW'(exp_valid));
      chk("m_out_entry", act_e, exp_e);
      if (flush) begin
         mq.delete();
      end else if (!byp) begin
         ndeq = (sz < LANES) ? sz : LANES;
         if (exp_wen)
            for (int k = 0; k < ndeq; k++) void'(mq.pop_front());
         if (exp_ready)
            foreach (lst[k]) mq.push_back(lst[k]);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic q,
                       input logic [LANES-1:0] v, input logic [OW-1:0] e);
      @(posedge clk);
      #1;
      reset = r;
      flush = f;
      iq_full = q;
      in_valid = v;
      in_entry = e;
      @(negedge clk);
      model_cycle();
   endtask

   function automatic logic [ENTRY_W-1:0] ent(input int i);
      return 64'hBEEF_0000_0000_0000 | 64'(i);
   endfunction

   logic [ENTRY_W-1:0] ea, eb, ec;

   initial begin
      ea = 64'hAAAA_AAAA_0000_0001;
      eb = 64'hBBBB_BBBB_0000_0002;
      ec = 64'hCCCC_CCCC_0000_0003;

      // Reset state, then one full group.
      step(1, 0, 0, '0, '0);
      step(0, 0, 0, '0, '0);
      chk("rst_count", OW'(count), '0);
      chk("rst_out_valid", OW'(out_valid), '0);
      chk("rst_out_wen", OW'(out_wen), '0);
      chk("rst_in_ready", OW'(in_ready), OW'(1));
`ifndef BR_DISPATCH_BYPASS_EN
      step(0, 0, 0, 2'b11, {eb, ea});
      chk("ab_accept_wen", OW'(out_wen), '0);
      step(0, 0, 0, '0, '0);
      chk("ab_valid", OW'(out_valid), OW'(2'b11));
      chk("ab_entry", out_entry, {eb, ea});
      chk("ab_wen", OW'(out_wen), OW'(1));
      chk("ab_count", OW'(count), OW'(2));
      step(0, 0, 0, '0, '0);
      chk("ab_drained", OW'(count), '0);
`else
      step(0, 0, 0, 2'b11, {eb, ea});
      chk("byp_wen", OW'(out_wen), OW'(1));
      chk("byp_valid", OW'(out_valid), OW'(2'b11));
      chk("byp_entry", out_entry, {eb, ea});
      chk("byp_count", OW'(count), '0);
      step(0, 0, 0, '0, '0);
      chk("byp_count_after", OW'(count), '0);
`endif

      // Fill while the issue queue is full, then drain in order.
      step(1, 0, 0, '0, '0);
      for (int g = 0; g < 4; g++)
         step(0, 0, 1, 2'b11, {ent(2*g+1), ent(2*g)});
      step(0, 0, 1, 2'b11, {ent(99), ent(98)});
      chk("full_count", OW'(count), OW'(8));
      chk("full_ready", OW'(in_ready), '0);
      for (int g = 0; g < 4; g++) begin
         step(0, 0, 0, '0, '0);
         chk("drain_count", OW'(count), OW'(8 - 2*g));
         chk("drain_entry", out_entry, {ent(2*g+1), ent(2*g)});
      end
      step(0, 0, 0, '0, '0);
      chk("drain_empty", OW'(count), '0);

      // Upper lane only: compacted into lane 0.
      step(1, 0, 0, '0, '0);
      step(0, 0, 1, 2'b10, {ec, 64'h0});
      step(0, 0, 1, '0, '0);
      chk("c_valid", OW'(out_valid), OW'(2'b01));
      chk("c_entry", OW'(out_entry[ENTRY_W-1:0]), OW'(ec));
      chk("c_count", OW'(count), OW'(1));
      step(0, 0, 0, '0, '0);
      chk("c_wen", OW'(out_wen), OW'(1));

      // Move pointers to 6, then wrap across the end of storage.
      step(1, 0, 0, '0, '0);
      for (int g = 0; g < 3; g++)
         step(0, 0, 1, 2'b11, {ent(50+2*g+1), ent(50+2*g)});
      for (int g = 0; g < 3; g++)
         step(0, 0, 0, '0, '0);
      for (int g = 0; g < 3; g++)
         step(0, 0, 1, 2'b11, {ent(20+2*g+1), ent(20+2*g)});
      for (int g = 0; g < 3; g++) begin
         step(0, 0, 0, '0, '0);
         chk("wrap_entry", out_entry, {ent(20+2*g+1), ent(20+2*g)});
      end
      step(0, 0, 0, '0, '0);
      chk("wrap_empty", OW'(count), '0);

      // Flush with count=5 drops the concurrent group.
      step(1, 0, 0, '0, '0);
      step(0, 0, 1, 2'b11, {ent(31), ent(30)});
      step(0, 0, 1, 2'b11, {ent(33), ent(32)});
      step(0, 0, 1, 2'b01, {ent(0), ent(34)});
      step(0, 1, 0, 2'b11, {ent(36), ent(35)});
      chk("flush_count_before", OW'(count), OW'(5));
      chk("flush_wen", OW'(out_wen), '0);
      step(0, 0, 1, '0, '0);
      chk("flush_count", OW'(count), '0);
      chk("flush_valid", OW'(out_valid), '0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 300) == 0,
              $urandom_range(0, 60) == 0,
              $urandom_range(0, 2) == 0,
              LANES'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/br_dispatch_queue.md
BR_DISPATCH_QUEUE -- requirements
Module: br_dispatch_queue

Interface
REQ-001 SHALL have parameter LANES, default 2, dispatch lanes per cycle (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, buffer entries; power of two, DEPTH >= 2*LANES.
REQ-003 SHALL have parameter ENTRY_W, default 64, width of one branch issue-queue write entry.
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port flush  input  1  pipeline flush; discards all buffered entries.
REQ-007 SHALL have port in_valid  input  LANES  per-lane valid from rename.
REQ-008 SHALL have port in_entry  input  LANES*ENTRY_W  per-lane entry; lane k occupies bits [k*ENTRY_W +: ENTRY_W].
REQ-009 SHALL have port in_ready  output  1  buffer can accept LANES entries this cycle.
REQ-010 SHALL have port iq_full  input  1  branch issue queue cannot take a write group this cycle.
REQ-011 SHALL have port out_wen  output  1  write group presented to the issue queue is consumed this cycle.
REQ-012 SHALL have port out_valid  output  LANES  per-lane valid toward the issue queue; always contiguous from lane 0.
REQ-013 SHALL have port out_entry  output  LANES*ENTRY_W  per-lane entry toward the issue queue, same packing as in_entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL be a circular FIFO with head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH.
REQ-016 SHALL compute in_ready = (DEPTH - count) >= LANES from registered state only, with no path from in_valid, iq_full or flush.
REQ-017 SHALL enqueue when in_ready=1 and any in_valid bit is set, writing valid lanes in ascending lane order to consecutive slots from tail (compaction, e.g. in_valid=2'b10 writes lane 1 to slot tail).
REQ-018 SHALL ignore in_valid when in_ready=0; upstream holds its inputs; an accepted group is all-or-nothing.
REQ-019 SHALL drive out_valid[k]=1 iff k < count, with out_entry lane k = slot (head+k) mod DEPTH.
REQ-020 SHALL assert out_wen = (count != 0) && !iq_full && !flush.
REQ-021 SHALL, when out_wen=1, advance head by min(count, LANES) and reduce count by the same amount.
REQ-022 SHALL apply simultaneous enqueue and dequeue in the same cycle: count_next = count + n_enq - n_deq.
REQ-023 SHALL, on flush=1, set count, head and tail to 0 next cycle, ignore in_valid in that cycle, and hold out_wen=0.
REQ-024 SHALL preserve program order: entries leave in exactly the order they were accepted, across pointer wrap.
REQ-025 SHALL keep count within 0..DEPTH; over- and underflow are impossible by construction.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, clear head, tail and count to 0; reset takes priority over flush, enqueue and dequeue.
REQ-027 SHALL drive out_valid=0, out_wen=0, count=0 and in_ready=1 in the cycle after reset.
REQ-028 SHALL leave the entry storage unreset; stale data is never exposed because out_valid masks it.

Configuration
REQ-029 SHALL support macro BR_DISPATCH_BYPASS_EN.
REQ-030 SHALL, with BR_DISPATCH_BYPASS_EN defined, when count=0, iq_full=0 and flush=0, present compacted incoming lanes directly on out_valid/out_entry and assert out_wen in the same cycle. Bypassed entries are not stored: zero-cycle latency.
REQ-031 SHALL, without BR_DISPATCH_BYPASS_EN, present an accepted entry on the outputs no earlier than the cycle after acceptance: minimum one-cycle latency.

Verification
REQ-032 SHALL cover: reset, then in_valid=2'b11 with entries A,B and iq_full=0 -> next cycle out_valid=2'b11, out_entry={B,A}, out_wen=1, count=2; count=0 the following cycle (no bypass build).
REQ-033 SHALL cover: iq_full=1 held while four groups of 2 are sent -> count=8 and in_ready=0; a fifth group is not accepted; releasing iq_full drains 2 per cycle in order.
REQ-034 SHALL cover: in_valid=2'b10 with entry C -> stored at slot 0, then out_valid=2'b01 with out_entry lane 0 = C.
REQ-035 SHALL cover: head=6, tail=6 with DEPTH=8, three groups enqueued -> entries read back in order across wrap through slots 6,7,0,1,2,3.
REQ-036 SHALL cover: count=5 and flush=1 together with in_valid=2'b11 -> next cycle count=0, out_valid=0; the new group is dropped.
REQ-037 SHALL cover: BR_DISPATCH_BYPASS_EN build, empty queue, iq_full=0, in_valid=2'b11 -> out_wen=1 in the same cycle with the inputs and count stays 0.
